// File: rtl/snax_streamer_simd_rescale_shell.sv
// NumLanes-wide signed rescale (zero-point, multiply, round-shift, clamp) behind a CSR-launched
// two-stage stallable pipeline. Optional macro SNAX_SIMD_SAT_COUNT_EN adds a clamped-lane counter in ro[2].
module snax_streamer_simd_rescale_shell #(
  parameter int unsigned NumLanes     = 64,
  parameter int unsigned InElemWidth  = 32,
  parameter int unsigned OutElemWidth = 8,
  parameter int unsigned DataWidthA   = NumLanes * InElemWidth,
  parameter int unsigned DataWidthB   = NumLanes * OutElemWidth,
  parameter int unsigned RegRWCount   = 5,
  parameter int unsigned RegROCount   = 3,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DataWidthA-1:0]   stream2acc_0_data_i,
  input  logic                    stream2acc_0_valid_i,
  output logic                    stream2acc_0_ready_o,
  output logic [DataWidthB-1:0]   acc2stream_0_data_o,
  output logic                    acc2stream_0_valid_o,
  input  logic                    acc2stream_0_ready_i,
  input  logic [RegDataWidth-1:0] csr_reg_set_i [RegRWCount],
  input  logic                    csr_reg_set_valid_i,
  output logic                    csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount]
);

  localparam int unsigned DW = InElemWidth + 1;
  localparam int unsigned PW = InElemWidth + 33;
  localparam int unsigned RW = PW + 1;

  typedef enum logic [0:0] {IdleSt = 1'b0, BusySt = 1'b1} state_e;

  state_e state_q, state_d;
  logic rdy_q;
  logic signed [7:0] in_zp_q, out_zp_q, max_q, min_q;
  logic signed [31:0] mult_q;
  logic [5:0] shift_q;
  logic [31:0] len_q, in_cnt_q, out_cnt_q, perf_q;
  logic s1_valid_q, out_valid_q;
  logic signed [PW-1:0] s1_prod_q [NumLanes];
  logic signed [PW-1:0] s1_prod_d [NumLanes];
  logic [DataWidthB-1:0] out_data_q, out_data_d;
  logic [NumLanes-1:0] clamp;
  logic launch, out_fire, out_adv, s1_ready, in_ready, in_fire;
  logic unused_cfg;

  assign launch   = csr_reg_set_valid_i && rdy_q;
  assign out_fire = out_valid_q && acc2stream_0_ready_i;
  assign out_adv  = !out_valid_q || acc2stream_0_ready_i;
  assign s1_ready = !s1_valid_q || out_adv;
  assign in_ready = (state_q == BusySt) && (in_cnt_q < len_q) && s1_ready;
  assign in_fire  = stream2acc_0_valid_i && in_ready;

  assign stream2acc_0_ready_o = in_ready;
  assign acc2stream_0_valid_o = out_valid_q;
  assign acc2stream_0_data_o  = out_data_q;
  assign csr_reg_set_ready_o  = rdy_q;
  assign unused_cfg = ^{csr_reg_set_i[4], csr_reg_set_i[2][RegDataWidth-1:6], RegAddrWidth};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IdleSt: begin
        if (launch && (csr_reg_set_i[3] != '0)) state_d = BusySt;
        else state_d = IdleSt;
      end
      BusySt: begin
        if (out_fire && (out_cnt_q == len_q - 32'd1)) state_d = IdleSt;
        else state_d = BusySt;
      end
      default: state_d = IdleSt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IdleSt;
      rdy_q     <= 1'b0;
      in_zp_q   <= '0;
      out_zp_q  <= '0;
      max_q     <= '0;
      min_q     <= '0;
      mult_q    <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      perf_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IdleSt);
      if (launch) begin
        in_zp_q   <= csr_reg_set_i[0][7:0];
        out_zp_q  <= csr_reg_set_i[0][15:8];
        max_q     <= csr_reg_set_i[0][23:16];
        min_q     <= csr_reg_set_i[0][31:24];
        mult_q    <= csr_reg_set_i[1];
        shift_q   <= csr_reg_set_i[2][5:0];
        len_q     <= csr_reg_set_i[3];
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        perf_q    <= '0;
      end else begin
        if (in_fire) in_cnt_q <= in_cnt_q + 32'd1;
        if (out_fire) out_cnt_q <= out_cnt_q + 32'd1;
        if ((state_q == BusySt) && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
      end
    end
  end

  // Stage 1: zero-point removal and full-precision product per lane
  always_comb begin
    logic signed [DW-1:0] lane_d;
    lane_d = '0;
    for (int i = 0; i < NumLanes; i++) begin
      lane_d = $signed({stream2acc_0_data_i[i*InElemWidth+InElemWidth-1],
                        stream2acc_0_data_i[i*InElemWidth +: InElemWidth]}) - DW'(in_zp_q);
      s1_prod_d[i] = PW'(lane_d) * PW'(mult_q);
    end
  end

  // Stage 2: one extra guard bit keeps product + rounding term from wrapping at full scale
  always_comb begin
    logic signed [RW-1:0] rnd, r, v, mx, mn;
    logic signed [7:0] o;
    out_data_d = '0;
    clamp      = '0;
    r          = '0;
    v          = '0;
    o          = '0;
    mx         = RW'(max_q);
    mn         = RW'(min_q);
    if (shift_q == 6'd0) rnd = '0;
    else rnd = RW'(1'b1) << (shift_q - 6'd1);
    for (int i = 0; i < NumLanes; i++) begin
      r = (RW'(s1_prod_q[i]) + rnd) >>> shift_q;
      v = r + RW'(out_zp_q);
      if (v > mx) begin
        o = max_q;
        clamp[i] = 1'b1;
      end else if (v < mn) begin
        o = min_q;
        clamp[i] = 1'b1;
      end else begin
        o = v[7:0];
        clamp[i] = 1'b0;
      end
      out_data_d[i*OutElemWidth +: OutElemWidth] = OutElemWidth'(o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NumLanes; i++) s1_prod_q[i] <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= in_fire;
        if (in_fire) begin
          for (int i = 0; i < NumLanes; i++) s1_prod_q[i] <= s1_prod_d[i];
        end
      end
      if (out_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= out_data_d;
      end
    end
  end

`ifdef SNAX_SIMD_SAT_COUNT_EN
  logic [31:0] sat_q, sat_d, clamp_sum;

  always_comb begin
    clamp_sum = '0;
    for (int i = 0; i < NumLanes; i++) clamp_sum = clamp_sum + {31'd0, clamp[i]};
    if (clamp_sum > (32'hFFFF_FFFF - sat_q)) sat_d = 32'hFFFF_FFFF;
    else sat_d = sat_q + clamp_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sat_q <= '0;
    else if (launch) sat_q <= '0;
    else if (out_adv && s1_valid_q) sat_q <= sat_d;
    else sat_q <= sat_q;
  end
`else
  logic unused_clamp;
  assign unused_clamp = ^clamp;
`endif

  always_comb begin
    for (int k = 0; k < RegROCount; k++) csr_reg_ro_set_o[k] = '0;
    csr_reg_ro_set_o[0] = RegDataWidth'(state_q == BusySt);
    csr_reg_ro_set_o[1] = perf_q;
`ifdef SNAX_SIMD_SAT_COUNT_EN
    csr_reg_ro_set_o[2] = sat_q;
`endif
  end

endmodule

// File: tb/tb_snax_streamer_simd_rescale_shell.sv
// Directed bench for snax_streamer_simd_rescale_shell: table of single-beat rescale vectors
// plus hand sequences for throughput, backpressure, length bound, control and mid-run reset.
module tb_snax_streamer_simd_rescale_shell;

  localparam int NL  = 64;
  localparam int IW  = 32;
  localparam int OW  = 8;
  localparam int DWA = NL * IW;
  localparam int DWB = NL * OW;

  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  ex_a;
    logic [7:0]  ex_b;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DWA-1:0] din;
  logic           din_valid;
  logic           in_ready;
  logic [DWB-1:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic [31:0]    csr_set [5];
  logic           csr_valid;
  logic           csr_ready;
  logic [31:0]    ro [3];

  int checks = 0;
  int errors = 0;
  int in_hs = 0;
  logic [DWB-1:0] got_q [$];

  snax_streamer_simd_rescale_shell dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .stream2acc_0_data_i (din),
    .stream2acc_0_valid_i(din_valid),
    .stream2acc_0_ready_o(in_ready),
    .acc2stream_0_data_o (dout),
    .acc2stream_0_valid_o(dout_valid),
    .acc2stream_0_ready_i(dout_ready),
    .csr_reg_set_i       (csr_set),
    .csr_reg_set_valid_i (csr_valid),
    .csr_reg_set_ready_o (csr_ready),
    .csr_reg_ro_set_o    (ro)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (din_valid && in_ready) in_hs <= in_hs + 1;
    if (dout_valid && dout_ready) got_q.push_back(dout);
  end

  task automatic chk(input string name, input logic [DWB-1:0] act, input logic [DWB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DWA-1:0] mk_in(input logic [31:0] a, input logic [31:0] b);
    logic [DWA-1:0] v;
    for (int i = 0; i < NL; i++) v[i*IW +: IW] = (i == 0) ? b : a;
    return v;
  endfunction

  function automatic logic [DWB-1:0] mk_out(input logic [7:0] a, input logic [7:0] b);
    logic [DWB-1:0] v;
    for (int i = 0; i < NL; i++) v[i*OW +: OW] = (i == 0) ? b : a;
    return v;
  endfunction

  function automatic logic [DWA-1:0] beat_in(input int k);
    return mk_in(32'(k + 1), 32'(k + 1));
  endfunction

  function automatic logic [DWB-1:0] beat_out(input int k);
    return mk_out(8'(k + 1), 8'(k + 1));
  endfunction

  task automatic launch(input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3);
    int n;
    n = 0;
    csr_set[0] = r0;
    csr_set[1] = r1;
    csr_set[2] = r2;
    csr_set[3] = r3;
    csr_set[4] = 32'hDEAD_BEEF;
    csr_valid  = 1'b1;
    while (!csr_ready && n < 20) begin
      tick();
      n++;
    end
    chk("launch_ready", csr_ready, 1'b1);
    tick();
    csr_valid = 1'b0;
  endtask

  task automatic check_outs(input string name, input int base, input int n);
    chk({name, "_out_count"}, got_q.size() - base, n);
    for (int k = 0; k < n && (base + k) < got_q.size(); k++)
      chk($sformatf("%s_out%0d", name, k), got_q[base + k], beat_out(k));
  endtask

  vec_t tv [7];
  int base_hs, base_q, cyc;

  initial begin
    tv[0] = '{32'h807F_FD02, 32'd5,         32'd2,         32'd10,        32'hFFFF_FFFA, 8'h07, 8'hF3};
    tv[1] = '{32'h807F_0000, 32'd3,         32'd1,         32'd100,       32'hFFFF_FF9C, 8'h7F, 8'h80};
    tv[2] = '{32'h807F_0500, 32'hFFFF_FFFE, 32'd0,         32'd7,         32'hFFFF_FFC4, 8'hF7, 8'h7D};
    tv[3] = '{32'h0AF6_0000, 32'd1,         32'd0,         32'd5,         32'hFFFF_FFEC, 8'hF6, 8'h0A};
    tv[4] = '{32'h807F_0080, 32'h7FFF_FFFF, 32'hABCD_EF3F, 32'h7FFF_FFFF, 32'h8000_0000, 8'h01, 8'h00};
    tv[5] = '{32'h807F_0000, 32'd1,         32'd4,         32'd8,         32'hFFFF_FFF8, 8'h01, 8'h00};
    tv[6] = '{32'hEC14_0A00, 32'd1,         32'd0,         32'd15,        32'hFFFF_FFDD, 8'h14, 8'hEC};

    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    csr_valid  = 1'b0;
    for (int k = 0; k < 5; k++) csr_set[k] = '0;
    #2;
    chk("rst_out_valid", dout_valid, 1'b0);
    chk("rst_out_data", dout, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_csr_ready", csr_ready, 1'b0);
    chk("rst_ro0", ro[0], 32'd0);
    chk("rst_ro1", ro[1], 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("post_rst_csr_ready", csr_ready, 1'b1);

    foreach (tv[i]) begin
      din       = mk_in(tv[i].in_a, tv[i].in_b);
      din_valid = 1'b0;
      launch(tv[i].r0, tv[i].r1, tv[i].r2, 32'd1);
      din_valid = 1'b1;
      chk($sformatf("tv%0d_in_ready", i), in_ready, 1'b1);
      tick();
      din_valid = 1'b0;
      chk($sformatf("tv%0d_no_early_valid", i), dout_valid, 1'b0);
      tick();
      chk($sformatf("tv%0d_valid", i), dout_valid, 1'b1);
      chk($sformatf("tv%0d_data", i), dout, mk_out(tv[i].ex_a, tv[i].ex_b));
      tick();
      chk($sformatf("tv%0d_idle", i), ro[0], 32'd0);
      chk($sformatf("tv%0d_csr_ready", i), csr_ready, 1'b1);
      chk($sformatf("tv%0d_perf", i), ro[1], 32'd3);
`ifdef SNAX_SIMD_SAT_COUNT_EN
      if (i == 1) chk("sat_count", ro[2], 32'(NL));
`else
      if (i == 1) chk("ro2_zero", ro[2], 32'd0);
`endif
    end

    launch(32'h807F_0000, 32'd1, 32'd0, 32'd0);
    chk("len0_idle", ro[0], 32'd0);
    chk("len0_perf_cleared", ro[1], 32'd0);
    chk("len0_csr_ready", csr_ready, 1'b1);
    tick();
    chk("len0_still_idle", ro[0], 32'd0);

    base_hs   = in_hs;
    base_q    = got_q.size();
    din       = beat_in(0);
    din_valid = 1'b1;
    launch(32'h807F_0000, 32'd1, 32'd0, 32'd4);
    cyc = 0;
    while (ro[0][0] && cyc < 40) begin
      din = beat_in(in_hs - base_hs);
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    chk("perf_run_idle", ro[0], 32'd0);
    chk("perf_count", ro[1], 32'd6);
    chk("perf_in_hs", in_hs - base_hs, 4);
    check_outs("perf", base_q, 4);

    base_hs   = in_hs;
    base_q    = got_q.size();
    din       = beat_in(0);
    din_valid = 1'b1;
    launch(32'h807F_0000, 32'd1, 32'd0, 32'd3);
    for (int c = 0; c < 10; c++) begin
      din = beat_in(in_hs - base_hs);
      tick();
    end
    din_valid = 1'b0;
    chk("lenb_idle", ro[0], 32'd0);
    chk("lenb_in_hs", in_hs - base_hs, 3);
    chk("lenb_perf", ro[1], 32'd5);
    check_outs("lenb", base_q, 3);

    base_hs    = in_hs;
    base_q     = got_q.size();
    dout_ready = 1'b0;
    din        = beat_in(0);
    din_valid  = 1'b1;
    launch(32'h807F_0000, 32'd1, 32'd0, 32'd4);
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        csr_set[1] = 32'd9;
        csr_set[3] = 32'd7;
        csr_valid  = 1'b1;
        chk("bp_csr_busy_ready", csr_ready, 1'b0);
      end
      if (c == 4) csr_valid = 1'b0;
      if (c >= 3) begin
        chk($sformatf("bp_in_ready_c%0d", c), in_ready, 1'b0);
        chk($sformatf("bp_valid_c%0d", c), dout_valid, 1'b1);
        chk($sformatf("bp_stable_c%0d", c), dout, beat_out(0));
      end
      din = beat_in(in_hs - base_hs);
      tick();
    end
    chk("bp_in_hs_stalled", in_hs - base_hs, 2);
    dout_ready = 1'b1;
    cyc = 0;
    while (ro[0][0] && cyc < 40) begin
      din = beat_in(in_hs - base_hs);
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    chk("bp_idle", ro[0], 32'd0);
    chk("bp_in_hs", in_hs - base_hs, 4);
    check_outs("bp", base_q, 4);

    base_hs   = in_hs;
    din       = beat_in(0);
    din_valid = 1'b1;
    launch(32'h807F_0000, 32'd1, 32'd0, 32'd4);
    cyc = 0;
    while ((in_hs - base_hs) < 2 && cyc < 20) begin
      din = beat_in(in_hs - base_hs);
      tick();
      cyc++;
    end
    chk("rr_valid_before_reset", dout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rr_out_valid", dout_valid, 1'b0);
    chk("rr_out_data", dout, '0);
    chk("rr_in_ready", in_ready, 1'b0);
    chk("rr_csr_ready", csr_ready, 1'b0);
    chk("rr_ro0", ro[0], 32'd0);
    chk("rr_ro1", ro[1], 32'd0);
    #2;
    rst_n     = 1'b1;
    din_valid = 1'b0;
    tick();
    tick();
    chk("rr_post_csr_ready", csr_ready, 1'b1);
    chk("rr_post_idle", ro[0], 32'd0);
    chk("rr_post_out_valid", dout_valid, 1'b0);

    base_q    = got_q.size();
    din       = mk_in(tv[0].in_a, tv[0].in_b);
    din_valid = 1'b1;
    launch(tv[0].r0, tv[0].r1, tv[0].r2, 32'd1);
    cyc = 0;
    while (ro[0][0] && cyc < 20) begin
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    chk("rr_new_idle", ro[0], 32'd0);
    chk("rr_new_count", got_q.size() - base_q, 1);
    if (got_q.size() > base_q)
      chk("rr_new_data", got_q[base_q], mk_out(tv[0].ex_a, tv[0].ex_b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
